// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Memory-side handshake between the fetch/execute sequencer and the memory
// interface.
//   mem_rd     sequencer -> memory  read request (instruction fetch or load)
//   mem_wr     sequencer -> memory  write request (store)
//   addr_sel   sequencer -> memory  0: address is pc, 1: address is ALU/register
//   mem_ready  memory -> sequencer  current read/write completes this cycle
// Modports: master (sequencer side), slave (memory side).
// -----------------------------------------------------------------------------
interface pc_sequencer_if;
  logic mem_rd;
  logic mem_wr;
  logic addr_sel;
  logic mem_ready;

  modport master (
    output mem_rd,
    output mem_wr,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_rd,
    input  mem_wr,
    input  addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Multicycle fetch/execute sequencer for the 16-bit core. Owns the
// architectural PC, drives the memory strobes, the IR / regfile / link write
// pulses and the one-hot jal/jump/branch enables for the PC-update ALU, whose
// result (pc_next) is loaded back into the PC when an instruction retires.
//
// Parameters
//   WIDTH       datapath, PC and retire-counter width
//   RESET_PC    PC value loaded on reset
//   IRQ_VECTOR  PC loaded on interrupt entry (only with PC_SEQ_IRQ_EN)
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   is_jal/is_jump/is_branch   decoded instruction class (latched in DECODE)
//   is_load/is_store/is_halt
//   cond_met                   condition check for jump/branch (latched in DECODE)
//   stall                      hold in EXEC
//   pc_next                    next-PC result from the PC-update ALU
//   pc                         architectural PC (registered)
//   ir_we, rf_we, link_we      single-cycle write pulses
//   jal_en, jump_en, branch_en PC-ALU selects, held through EXEC/MEM
//   state                      FETCH=0 DECODE=1 EXEC=2 MEM=3 HALT=4
//   retired                    instructions-retired counter (wraps)
//   bus                        memory handshake (pc_sequencer_if.master)
//
// Optional feature macro: PC_SEQ_IRQ_EN
//   Adds irq (in), irq_ack (out) and epc (out). irq is sampled only when an
//   instruction retires back to FETCH; a taken interrupt saves pc_next in epc
//   and redirects the PC to IRQ_VECTOR. A halt retire never takes an interrupt.
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int                 WIDTH    = 16,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
`ifdef PC_SEQ_IRQ_EN
  ,
  parameter logic [WIDTH-1:0]   IRQ_VECTOR = 16'h0010
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_jal,
  input  logic              is_jump,
  input  logic              is_branch,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              is_halt,
  input  logic              cond_met,
  input  logic              stall,
  input  logic [WIDTH-1:0]  pc_next,
  output logic [WIDTH-1:0]  pc,
  output logic              ir_we,
  output logic              rf_we,
  output logic              link_we,
  output logic              jal_en,
  output logic              jump_en,
  output logic              branch_en,
  output logic [2:0]        state,
  output logic [WIDTH-1:0]  retired,
`ifdef PC_SEQ_IRQ_EN
  input  logic              irq,
  output logic              irq_ack,
  output logic [WIDTH-1:0]  epc,
`endif
  pc_sequencer_if.master    bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Instruction class captured at the end of DECODE; only read in EXEC/MEM,
  // so it needs no reset.
  logic cls_jal, cls_jump, cls_branch, cls_load, cls_store, cls_halt, cls_cond;

  logic             pc_load;
  logic             ret_inc;
  logic [WIDTH-1:0] pc_d;

  // Priority-encoded PC-ALU selects: jal over jump over branch. An untaken
  // jump/branch leaves all three low so the ALU falls back to pc+1.
  logic sel_jal, sel_jump, sel_branch;
  assign sel_jal    = cls_jal;
  assign sel_jump   = ~cls_jal & cls_jump & cls_cond;
  assign sel_branch = ~cls_jal & ~cls_jump & cls_branch & cls_cond;

  assign state = state_q;

  // Registered state: FSM, PC, retire counter, class latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc      <= RESET_PC;
      retired <= '0;
`ifdef PC_SEQ_IRQ_EN
      epc     <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (pc_load) pc <= pc_d;
      if (ret_inc) retired <= retired + WIDTH'(1);
`ifdef PC_SEQ_IRQ_EN
      if (pc_load && irq) epc <= pc_next;
`endif
      if (state_q == DECODE) begin
        cls_jal    <= is_jal;
        cls_jump   <= is_jump;
        cls_branch <= is_branch;
        cls_load   <= is_load;
        cls_store  <= is_store;
        cls_halt   <= is_halt;
        cls_cond   <= cond_met;
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d      = state_q;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.addr_sel = 1'b0;
    ir_we        = 1'b0;
    rf_we        = 1'b0;
    link_we      = 1'b0;
    jal_en       = 1'b0;
    jump_en      = 1'b0;
    branch_en    = 1'b0;
    pc_load      = 1'b0;
    ret_inc      = 1'b0;
    pc_d         = pc_next;
`ifdef PC_SEQ_IRQ_EN
    irq_ack      = 1'b0;
`endif

    case (state_q)
      FETCH: begin
        bus.mem_rd = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end

      DECODE: state_d = EXEC;

      EXEC: begin
        jal_en    = sel_jal;
        jump_en   = sel_jump;
        branch_en = sel_branch;
        if (!stall) begin
          if (cls_halt) begin
            // Halt counts as retired but keeps the PC where it is.
            ret_inc = 1'b1;
            state_d = HALT;
          end else if (cls_load || cls_store) begin
            state_d = MEM;
          end else begin
            link_we = cls_jal;
            pc_load = 1'b1;
            ret_inc = 1'b1;
            state_d = FETCH;
          end
        end
      end

      MEM: begin
        jal_en       = sel_jal;
        jump_en      = sel_jump;
        branch_en    = sel_branch;
        bus.addr_sel = 1'b1;
        bus.mem_rd   = cls_load;
        // A load/store combination is treated as a load.
        bus.mem_wr   = cls_store & ~cls_load;
        if (bus.mem_ready) begin
          rf_we   = cls_load;
          pc_load = 1'b1;
          ret_inc = 1'b1;
          state_d = FETCH;
        end
      end

      HALT: state_d = HALT;

      default: state_d = FETCH;
    endcase

`ifdef PC_SEQ_IRQ_EN
    // pc_load is only raised on a retire back to FETCH, never for halt.
    if (pc_load && irq) begin
      pc_d    = IRQ_VECTOR;
      irq_ack = 1'b1;
    end
`endif

    // The reset cycle abandons whatever was in flight: no strobes leave.
    if (reset) begin
      bus.mem_rd   = 1'b0;
      bus.mem_wr   = 1'b0;
      bus.addr_sel = 1'b0;
      ir_we        = 1'b0;
      rf_we        = 1'b0;
      link_we      = 1'b0;
      jal_en       = 1'b0;
      jump_en      = 1'b0;
      branch_en    = 1'b0;
      pc_load      = 1'b0;
      ret_inc      = 1'b0;
`ifdef PC_SEQ_IRQ_EN
      irq_ack      = 1'b0;
`endif
    end
  end

endmodule
